// File: rtl/fmac_sfifo_param_if.sv
// Port bundle for the single-clock FIFO: write/read requests, flush, read data and status flags.
// Handshake: a write is taken on a rising edge when wrreq=1 and full=0; a read when rdreq=1 and empty=0.
//   Requests against a full or empty FIFO are dropped and raise the sticky ovf/unf flags.
interface fmac_sfifo_param_if #(
  parameter int WIDTH = 64,
  parameter int PTR   = 12
);
  logic             sclr;
  logic             wrreq;
  logic [WIDTH-1:0] data;
  logic             rdreq;
  logic [WIDTH-1:0] q;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [PTR:0]     usedw;
  logic             ovf;
  logic             unf;

  modport master (
    output sclr, wrreq, data, rdreq,
    input  q, full, empty, almost_full, almost_empty, usedw, ovf, unf
  );

  modport slave (
    input  sclr, wrreq, data, rdreq,
    output q, full, empty, almost_full, almost_empty, usedw, ovf, unf
  );
endinterface

// File: rtl/fmac_sfifo_param.sv
// Parametrised single-clock FIFO with exact usedw, almost flags, sticky ovf/unf and sync flush.
// Define FMAC_SFIFO_SHOWAHEAD_EN for show-ahead (first-word-fall-through) reads.
module fmac_sfifo_param #(
  parameter int WIDTH    = 64,
  parameter int DEPTH    = 4096,
  parameter int PTR      = 12,
  parameter int AF_LEVEL = 4088,
  parameter int AE_LEVEL = 8
) (
  input  logic               clk,
  input  logic               aclr,
  fmac_sfifo_param_if.slave  bus
);
  localparam logic [PTR:0] PTR_ONE  = (PTR+1)'(1);
  localparam logic [PTR:0] CNT_FULL = (PTR+1)'(DEPTH);
  localparam logic [PTR:0] CNT_AF   = (PTR+1)'(AF_LEVEL);
  localparam logic [PTR:0] CNT_AE   = (PTR+1)'(AE_LEVEL);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR:0]     wr_ptr, rd_ptr, wr_ptr_next, rd_ptr_next, cnt_next;
  logic [PTR:0]     usedw_r;
  logic             wr_ok, rd_ok;
  logic             full_r, empty_r, af_r, ae_r, ovf_r, unf_r;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] head_next;

  // Acceptance is judged on the registered flags, i.e. the state at the start of the cycle.
  always_comb begin
    wr_ok       = bus.wrreq && !full_r;
    rd_ok       = bus.rdreq && !empty_r;
    wr_ptr_next = wr_ptr;
    rd_ptr_next = rd_ptr;
    if (bus.sclr) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
    end else begin
      if (wr_ok) wr_ptr_next = wr_ptr + PTR_ONE;
      if (rd_ok) rd_ptr_next = rd_ptr + PTR_ONE;
    end
    cnt_next = wr_ptr_next - rd_ptr_next;
    // Head word after this edge; bypass when it is the word being written right now.
    if (wr_ok && (rd_ptr_next == wr_ptr)) head_next = bus.data;
    else                                  head_next = mem[rd_ptr_next[PTR-1:0]];
  end

  always_ff @(posedge clk) begin
    if (wr_ok && !bus.sclr) mem[wr_ptr[PTR-1:0]] <= bus.data;
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      usedw_r <= '0;
      full_r  <= 1'b0;
      empty_r <= 1'b1;
      af_r    <= 1'b0;
      ae_r    <= 1'b1;
      ovf_r   <= 1'b0;
      unf_r   <= 1'b0;
      q_r     <= '0;
    end else begin
      wr_ptr  <= wr_ptr_next;
      rd_ptr  <= rd_ptr_next;
      usedw_r <= cnt_next;
      full_r  <= (cnt_next == CNT_FULL);
      empty_r <= (cnt_next == '0);
      af_r    <= (cnt_next >= CNT_AF);
      ae_r    <= (cnt_next <= CNT_AE);
      if (bus.sclr) begin
        ovf_r <= 1'b0;
        unf_r <= 1'b0;
      end else begin
        if (bus.wrreq && full_r)  ovf_r <= 1'b1;
        if (bus.rdreq && empty_r) unf_r <= 1'b1;
      end
`ifdef FMAC_SFIFO_SHOWAHEAD_EN
      if (!bus.sclr && (cnt_next != '0)) q_r <= head_next;
`else
      if (!bus.sclr && rd_ok) q_r <= mem[rd_ptr[PTR-1:0]];
`endif
    end
  end

  assign bus.q            = q_r;
  assign bus.full         = full_r;
  assign bus.empty        = empty_r;
  assign bus.almost_full  = af_r;
  assign bus.almost_empty = ae_r;
  assign bus.usedw        = usedw_r;
  assign bus.ovf          = ovf_r;
  assign bus.unf          = unf_r;
endmodule

// File: tb/tb_fmac_sfifo_param.sv
// Self-checking bench for fmac_sfifo_param: queue scoreboard plus a count model for the flags.
// Build with FMAC_SFIFO_SHOWAHEAD_EN defined to exercise the show-ahead read mode.
module tb_fmac_sfifo_param;
  localparam int W     = 64;
  localparam int DEPTH = 4096;
  localparam int PTR   = 12;
  localparam int AF    = 4088;
  localparam int AE    = 8;

  logic clk = 1'b0;
  logic aclr = 1'b0;
  always #5 clk = ~clk;

  fmac_sfifo_param_if #(.WIDTH(W), .PTR(PTR)) bus ();

  fmac_sfifo_param #(
    .WIDTH(W), .DEPTH(DEPTH), .PTR(PTR), .AF_LEVEL(AF), .AE_LEVEL(AE)
  ) dut (
    .clk  (clk),
    .aclr (aclr),
    .bus  (bus)
  );

  logic [W-1:0] exp_q[$];
  int           m_cnt;
  logic         m_ovf, m_unf;
  logic [W-1:0] m_q;
  int           n_pass  = 0;
  int           n_total = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
  endtask

  task automatic check_flags(input string tag);
    check({tag, ":usedw"}, W'(bus.usedw),        W'(m_cnt));
    check({tag, ":full"},  W'(bus.full),         W'(m_cnt == DEPTH));
    check({tag, ":empty"}, W'(bus.empty),        W'(m_cnt == 0));
    check({tag, ":af"},    W'(bus.almost_full),  W'(m_cnt >= AF));
    check({tag, ":ae"},    W'(bus.almost_empty), W'(m_cnt <= AE));
    check({tag, ":ovf"},   W'(bus.ovf),          W'(m_ovf));
    check({tag, ":unf"},   W'(bus.unf),          W'(m_unf));
  endtask

  function automatic logic [W-1:0] rnd_word();
    return {$urandom(), $urandom()};
  endfunction

  // Called at posedge+1: drives one cycle of requests, then checks after the next edge.
  task automatic drive(input logic w, input logic [W-1:0] d, input logic r);
    logic         w_ok, r_ok;
    logic [W-1:0] popped;
    popped    = '0;
    bus.sclr  = 1'b0;
    bus.wrreq = w;
    bus.data  = d;
    bus.rdreq = r;
    w_ok = w && (m_cnt != DEPTH);
    r_ok = r && (m_cnt != 0);
    if (w && !w_ok) m_ovf = 1'b1;
    if (r && !r_ok) m_unf = 1'b1;
    if (r_ok) popped = exp_q.pop_front();
    if (w_ok) exp_q.push_back(d);
    m_cnt = m_cnt + int'(w_ok) - int'(r_ok);
`ifdef FMAC_SFIFO_SHOWAHEAD_EN
    if (r_ok) check("q_pop", bus.q, popped);
`endif
    @(posedge clk);
    #1;
    bus.wrreq = 1'b0;
    bus.rdreq = 1'b0;
    check("usedw", W'(bus.usedw), W'(m_cnt));
`ifdef FMAC_SFIFO_SHOWAHEAD_EN
    if (m_cnt != 0) begin
      m_q = exp_q[0];
      check("q_head", bus.q, m_q);
    end
`else
    if (r_ok) begin
      m_q = popped;
      check("q_read", bus.q, m_q);
    end
`endif
  endtask

  task automatic do_sclr(input logic w);
    bus.sclr  = 1'b1;
    bus.wrreq = w;
    bus.data  = rnd_word();
    bus.rdreq = 1'b1;
    @(posedge clk);
    #1;
    bus.sclr  = 1'b0;
    bus.wrreq = 1'b0;
    bus.rdreq = 1'b0;
    exp_q.delete();
    m_cnt = 0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  // Asserts aclr between edges and checks outputs before any clock edge.
  task automatic apply_reset(input string tag);
    aclr = 1'b1;
    #1;
    exp_q.delete();
    m_cnt = 0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_q   = '0;
    check_flags(tag);
    check({tag, ":q"}, bus.q, '0);
    @(negedge clk);
    aclr = 1'b0;
    @(posedge clk);
    #1;
  endtask

  function automatic bit at_level(input int c);
    return (c == AE) || (c == AE + 1) || (c == AF - 1) || (c == AF);
  endfunction

  initial begin
    bus.sclr  = 1'b0;
    bus.wrreq = 1'b0;
    bus.rdreq = 1'b0;
    bus.data  = '0;
    m_cnt = 0; m_ovf = 1'b0; m_unf = 1'b0; m_q = '0;
    #2;
    apply_reset("reset");

    // Basic ordered transfer
    for (int i = 0; i < 4; i++) drive(1'b1, W'(64'h11 * (i + 1)), 1'b0);
    check_flags("s1_wr");
    for (int i = 0; i < 4; i++) drive(1'b0, '0, 1'b1);
    check_flags("s1_rd");

    // Fill to full, stepping through the almost thresholds
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, rnd_word(), 1'b0);
      if (at_level(m_cnt)) check_flags("lvl_up");
    end
    check_flags("s2_full");
    drive(1'b1, 64'hDEAD_BEEF_0BAD_F00D, 1'b0);
    check_flags("s2_ovf");
    drive(1'b1, 64'hBAD0_BAD1_BAD2_BAD3, 1'b1);
    check_flags("s2_full_rw");
    while (m_cnt > 0) begin
      drive(1'b0, '0, 1'b1);
      if (at_level(m_cnt)) check_flags("lvl_dn");
    end
    check_flags("s2_drained");

    // Underflow, then flush with a competing write
    drive(1'b0, '0, 1'b1);
    check("s3_q_hold", bus.q, m_q);
    check_flags("s3_unf");
    do_sclr(1'b1);
    check_flags("s3_sclr");
    check("s3_q_sclr", bus.q, m_q);

    // Write and read together on an empty FIFO
    drive(1'b1, 64'h0123_4567_89AB_CDEF, 1'b1);
    check_flags("empty_rw");
    drive(1'b0, '0, 1'b1);
    do_sclr(1'b0);

    // Half full, streaming across several pointer wraps
    for (int i = 0; i < DEPTH / 2; i++) drive(1'b1, rnd_word(), 1'b0);
    for (int i = 0; i < 3 * DEPTH; i++) drive(1'b1, rnd_word(), 1'b1);
    check_flags("s4_stream");

    // Random mix of requests
    for (int i = 0; i < 600; i++)
      drive(1'($urandom_range(0, 1)), rnd_word(), 1'($urandom_range(0, 1)));
    check_flags("mix");

    // Asynchronous reset mid-operation, then recovery
    #3;
    apply_reset("aclr_mid");
    drive(1'b1, 64'h5A5A_5A5A_A5A5_A5A5, 1'b0);
    drive(1'b0, '0, 1'b1);
    check_flags("recover");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
